// File: rtl/bp_lce_req_arbiter.sv
// bp_lce_req_arbiter: round-robin, credit-limited sharing of one ready_then LCE request port.
// Optional BP_LCE_REQ_ARB_PERF_EN adds grant_count_o and stall_o.
module bp_lce_req_arbiter #(
    parameter  int num_req_p     = 2,
    parameter  int msg_width_p   = 512,
    parameter  int credits_p     = 8,
    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int cnt_width_lp  = $clog2(credits_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             req_pending_i,
    input  logic [num_req_p*msg_width_p-1:0] req_i,
    input  logic [num_req_p-1:0]             req_v_i,
    output logic [num_req_p-1:0]             req_ready_then_o,
    input  logic [num_req_p-1:0]             complete_i,
    output logic [num_req_p-1:0]             credits_full_o,
    output logic [num_req_p-1:0]             credits_empty_o,
    output logic [msg_width_p-1:0]           lce_req_o,
    output logic                             lce_req_v_o,
    input  logic                             lce_req_ready_then_i
`ifdef BP_LCE_REQ_ARB_PERF_EN
   ,output logic [num_req_p*32-1:0]          grant_count_o
   ,output logic                             stall_o
`endif
);

    typedef enum logic [1:0] {e_reset, e_arb, e_grant} state_e;

    state_e                   state_q, state_d;
    logic [lg_num_req_lp-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, winner;
    logic [cnt_width_lp-1:0]  count_q [num_req_p];
    logic [cnt_width_lp-1:0]  count_d [num_req_p];
    logic [num_req_p-1:0]     eligible;
    logic                     any_eligible;

    assign eligible = req_pending_i & ~credits_full_o;

    // Descending scan so the lowest offset from rr_ptr_q wins.
    always_comb begin
        winner       = rr_ptr_q;
        any_eligible = 1'b0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr_q) + k) % num_req_p]) begin
                winner       = lg_num_req_lp'((int'(rr_ptr_q) + k) % num_req_p);
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        rr_ptr_d         = rr_ptr_q;
        req_ready_then_o = '0;
        lce_req_v_o      = 1'b0;
        lce_req_o        = '0;
        case (state_q)
            e_reset: state_d = e_arb;
            e_arb: begin
                if (any_eligible) begin
                    owner_d = winner;
                    state_d = e_grant;
                end
            end
            e_grant: begin
                req_ready_then_o[owner_q] = lce_req_ready_then_i;
                lce_req_v_o               = req_v_i[owner_q] & lce_req_ready_then_i;
                lce_req_o                 = lce_req_v_o ? req_i[int'(owner_q)*msg_width_p +: msg_width_p] : '0;
                if (lce_req_v_o) begin
                    rr_ptr_d = (owner_q == lg_num_req_lp'(num_req_p - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = e_arb;
                end else if (!req_pending_i[owner_q]) begin
                    state_d = e_arb;
                end
            end
            default: state_d = e_reset;
        endcase
    end

    // A send and a completion in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            count_d[i]         = count_q[i];
            credits_full_o[i]  = count_q[i] == cnt_width_lp'(credits_p);
            credits_empty_o[i] = count_q[i] == '0;
            if (lce_req_v_o && int'(owner_q) == i && !(complete_i[i] && count_q[i] != '0))
                count_d[i] = count_q[i] + cnt_width_lp'(1);
            else if (!(lce_req_v_o && int'(owner_q) == i) && complete_i[i] && count_q[i] != '0)
                count_d[i] = count_q[i] - cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_reset;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < num_req_p; i++) count_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < num_req_p; i++) count_q[i] <= count_d[i];
        end
    end

    a_v_needs_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (req_v_i & ~req_ready_then_o) == '0);
    a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (complete_i & credits_empty_o) == '0);

`ifdef BP_LCE_REQ_ARB_PERF_EN
    logic [31:0] grant_cnt_q [num_req_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_req_p; i++) grant_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++)
                if (lce_req_v_o && int'(owner_q) == i && grant_cnt_q[i] != '1)
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
    end

    for (genvar g = 0; g < num_req_p; g++) begin : g_perf
        assign grant_count_o[g*32 +: 32] = grant_cnt_q[g];
    end

    assign stall_o = (state_q == e_grant) & ~lce_req_ready_then_i;
`endif

endmodule

// File: doc/bp_lce_req_arbiter.md
Name: bp_lce_req_arbiter

Overview:
Shares one LCE request network port (ready->valid, "ready_then" style) between num_req_p LCE request handlers, e.g. several cache engines behind one coherence NoC link.
- Round-robin arbitration; the winner gets a dedicated send slot.
- Per-requester outstanding-transaction credits; requesters at their credit limit are excluded from arbitration.
- Sits between the per-cache LCE request handlers and the coherence network request link.

Parameters:
num_req_p, 2, number of requesters (2..8)
msg_width_p, 512, width of one LCE request message in bits
credits_p, 8, max outstanding requests per requester (>=1)
lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), owner index width (localparam)
cnt_width_lp, `BSG_WIDTH(credits_p), credit counter width (localparam)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
req_pending_i  in  num_req_p  requester i has a message waiting for a slot
req_i  in  num_req_p*msg_width_p  request messages, slice i belongs to requester i
req_v_i  in  num_req_p  message valid; legal only in a cycle where req_ready_then_o[i]=1
req_ready_then_o  out  num_req_p  requester i may assert req_v_i this cycle
complete_i  in  num_req_p  one-cycle credit return per finished transaction
credits_full_o  out  num_req_p  requester i count == credits_p
credits_empty_o  out  num_req_p  requester i count == 0
lce_req_o  out  msg_width_p  forwarded message
lce_req_v_o  out  1  forwarded valid
lce_req_ready_then_i  in  1  network can accept a message this cycle

Behaviour:
Interface:
- One clock, clk_i; reset_n_i is asynchronous, active-low.
- All state is cleared on reset_n_i assertion regardless of clock.

Reset values:
- state=e_reset, owner_r=0, rr_ptr_r=0, all counts=0.
- req_ready_then_o=0, lce_req_v_o=0, lce_req_o=0.
- credits_empty_o=all 1s, credits_full_o=0.

FSM (e_reset, e_arb, e_grant):
- e_reset: go to e_arb on the first clock after deassertion.
- e_arb:
  - eligible[i] = req_pending_i[i] & ~credits_full_o[i].
  - Pick the first eligible index at or after rr_ptr_r, wrapping modulo num_req_p.
  - If any requester is eligible: owner_r <= winner, go to e_grant. Otherwise stay.
  - No ready_then is asserted in e_arb, so grant latency is 1 cycle after pending is seen.
- e_grant:
  - req_ready_then_o[owner_r] = lce_req_ready_then_i; all other bits 0.
  - lce_req_v_o = req_v_i[owner_r] & req_ready_then_o[owner_r]. lce_req_o = slice owner_r when valid, else 0.
  - On lce_req_v_o: rr_ptr_r <= (owner_r+1) mod num_req_p, go to e_arb.
  - If req_pending_i[owner_r] drops with no send: go to e_arb, rr_ptr_r unchanged.
  - Otherwise hold e_grant indefinitely.
- req_v_i[i] without req_ready_then_o[i] is ignored (simulation assertion fires).

Credits:
- count[i] +1 on a forwarded message from i; -1 on complete_i[i].
- Both in the same cycle: count unchanged.
- complete_i[i] at count 0: count stays 0, assertion fires.
- Full requester: never selected in e_arb. A requester already owning e_grant has count < credits_p, so it cannot overflow.

Other boundary conditions:
- Single eligible requester: it wins every arbitration.
- Asynchronous reset mid-e_grant: all outputs drop immediately; any in-flight message is lost, and the requesters own the retry.

Optional Feature:
BP_LCE_REQ_ARB_PERF_EN
- Defined: adds output grant_count_o (num_req_p*32).
  - Per-requester saturating counters of forwarded messages; reset to 0; held at 2^32-1 on saturation.
  - Adds output stall_o (1): high in e_grant while lce_req_ready_then_i=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n_i=0 for 3 cycles, then release -> all outputs at reset values; e_arb entered after 1 clock; credits_empty_o=2'b11.
- Alternation: num_req_p=2, both pending continuously, network always ready, each sends on ready_then -> forward order 0,1,0,1; one message every 2 cycles.
- Credit limit: credits_p=2, requester 0 sends 2 messages with no complete -> credits_full_o[0]=1 and requester 1 wins while 0 is still pending. One complete_i[0] pulse -> full clears next cycle and 0 is eligible again.
- Simultaneous credit events: requester 0 at count 1, complete_i[0] in the same cycle as a forwarded send from 0 -> count stays 1.
- Backpressure: lce_req_ready_then_i=0 for 5 cycles in e_grant -> req_ready_then_o=0 and no forward; after release, the send occurs and the owner is unchanged.
- Abandon and async reset:
  - Owner drops pending in e_grant -> returns to e_arb with rr_ptr_r unchanged.
  - reset_n_i asserted mid-e_grant, between clock edges -> lce_req_v_o and req_ready_then_o go 0 immediately.
